// File: rtl/scan_index_sequencer_pkg.sv
// Shared constants for the scan index sequencer: FSM state encodings and the all-masked value.
package scan_index_sequencer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  localparam logic [7:0] MASK_ALL = 8'hFF;

endpackage

// File: rtl/scan_index_sequencer_next_index_finder.sv
// Combinational search for the nearest unmasked position after idx_i in direction dir_i.
module scan_index_sequencer_next_index_finder (
  input  logic [2:0] idx_i,
  input  logic       dir_i,
  input  logic [7:0] skip_mask_i,
  output logic [2:0] nxt_o,
  output logic       found_o,
  output logic       wraps_o
);

  logic [2:0] cand;

  always_comb begin
    nxt_o   = idx_i;
    found_o = 1'b0;
    wraps_o = 1'b0;
    cand    = 3'd0;
    // Farthest candidate first so the nearest unmasked one is the last to overwrite.
    for (int k = 7; k >= 1; k--) begin
      cand = dir_i ? (idx_i - 3'(k)) : (idx_i + 3'(k));
      if (!skip_mask_i[cand]) begin
        nxt_o   = cand;
        found_o = 1'b1;
        wraps_o = dir_i ? (cand > idx_i) : (cand < idx_i);
      end
    end
  end

endmodule

// File: rtl/scan_index_sequencer.sv
// Prescaled 3-bit index stepper with up/down, load and skip mask; drives a 3-8 decoder select.
module scan_index_sequencer
  import scan_index_sequencer_pkg::*;
#(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       dir_i,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  input  logic [7:0] skip_mask_i,
  output logic [2:0] idx_o,
  output logic       idx_valid_o,
  output logic       wrap_o,
  output logic       busy_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(PRESCALE - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             wrap_q, wrap_d;

  logic       run;
  logic       tick;
  logic [2:0] nxt;
  logic       found;
  logic       wraps;

  scan_index_sequencer_next_index_finder u_finder (
    .idx_i       (idx_q),
    .dir_i       (dir_i),
    .skip_mask_i (skip_mask_i),
    .nxt_o       (nxt),
    .found_o     (found),
    .wraps_o     (wraps)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: en low always returns to idle, a fully masked ring stalls.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else if (skip_mask_i == MASK_ALL) begin
      state_d = ST_STALL;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Output logic
  always_comb begin
    idx_o       = idx_q;
    idx_valid_o = (state_q == ST_RUN) && !skip_mask_i[idx_q];
    wrap_o      = wrap_q;
    busy_o      = (state_q != ST_IDLE);
  end

  assign run  = en_i && (state_q == ST_RUN);
  assign tick = run && (cnt_q == CntMax);

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load_i) begin
      idx_d = load_val_i;
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      if (found) begin
        idx_d  = nxt;
        wrap_d = wraps;
      end
    end else if (run) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= 3'd0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

endmodule

// File: tb/tb_scan_index_sequencer.sv
// Directed-vector bench for scan_index_sequencer with PRESCALE=4.
module tb_scan_index_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dir;
  logic       load;
  logic [2:0] load_val;
  logic [7:0] skip_mask;
  logic [2:0] idx;
  logic       idx_valid;
  logic       wrap;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scan_index_sequencer #(
    .PRESCALE (4),
    .CNT_W    (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .dir_i       (dir),
    .load_i      (load),
    .load_val_i  (load_val),
    .skip_mask_i (skip_mask),
    .idx_o       (idx),
    .idx_valid_o (idx_valid),
    .wrap_o      (wrap),
    .busy_o      (busy)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_seq2 [5] = '{1, 3, 5, 7, 1};
  int exp_wr2  [5] = '{0, 0, 0, 0, 1};
  int exp_seq3 [3] = '{1, 0, 7};
  int exp_wr3  [3] = '{0, 0, 1};

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = 3'd0; skip_mask = 8'h00;
    step(2);
    check_eq("rst_idx", idx, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wrap", wrap, 0);
    check_eq("rst_valid", idx_valid, 0);

    // Free run up, no mask: step every 4 cycles, wrap only at 7->0.
    rst = 1'b0; en = 1'b1;
    step(1);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_valid", idx_valid, 1);
    for (int i = 1; i <= 8; i++) begin
      step(3);
      check_eq("t1_hold", idx, (i - 1) % 8);
      check_eq("t1_nowrap", wrap, 0);
      step(1);
      check_eq("t1_idx", idx, i % 8);
      check_eq("t1_wrap", wrap, (i == 8) ? 1 : 0);
    end

    // Odd positions only.
    skip_mask = 8'b0101_0101;
    #1;
    check_eq("t2_masked_valid", idx_valid, 0);
    for (int i = 0; i < 5; i++) begin
      step(4);
      check_eq("t2_idx", idx, exp_seq2[i]);
      check_eq("t2_wrap", wrap, exp_wr2[i]);
      check_eq("t2_valid", idx_valid, 1);
    end

    // Down count after a load.
    dir = 1'b1; skip_mask = 8'h00; load = 1'b1; load_val = 3'd2;
    step(1);
    load = 1'b0;
    check_eq("t3_load", idx, 2);
    check_eq("t3_load_wrap", wrap, 0);
    for (int i = 0; i < 3; i++) begin
      step(4);
      check_eq("t3_idx", idx, exp_seq3[i]);
      check_eq("t3_wrap", wrap, exp_wr3[i]);
    end

    // Load beats coincident tick, and restarts the prescaler.
    step(3);
    load = 1'b1; load_val = 3'd5;
    step(1);
    load = 1'b0;
    check_eq("t4_load", idx, 5);
    check_eq("t4_wrap", wrap, 0);
    step(3);
    check_eq("t4_hold", idx, 5);
    step(1);
    check_eq("t4_step", idx, 4);

    // Full mask stalls; releasing all but position 4 resumes to 4.
    dir = 1'b0; load = 1'b1; load_val = 3'd1;
    step(1);
    load = 1'b0;
    step(2);
    skip_mask = 8'hFF;
    #1;
    check_eq("t5_valid_comb", idx_valid, 0);
    step(1);
    check_eq("t5_stall_busy", busy, 1);
    step(4);
    check_eq("t5_frozen", idx, 1);
    check_eq("t5_stall_valid", idx_valid, 0);
    skip_mask = 8'hEF;
    step(1);
    check_eq("t5_resume_idx", idx, 1);
    check_eq("t5_resume_valid", idx_valid, 0);
    step(1);
    check_eq("t5_idx", idx, 4);
    check_eq("t5_valid", idx_valid, 1);
    check_eq("t5_wrap", wrap, 0);

    // Reset mid-count (cnt=2, idx=6).
    skip_mask = 8'h00; load = 1'b1; load_val = 3'd6;
    step(1);
    load = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_eq("t6_idx", idx, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_wrap", wrap, 0);
    check_eq("t6_valid", idx_valid, 0);
    step(4);
    check_eq("t6_cnt_hold", idx, 0);
    step(1);
    check_eq("t6_cnt_zero", idx, 1);

    // en low freezes the count; resume from the frozen value.
    step(2);
    en = 1'b0;
    step(3);
    check_eq("fz_busy", busy, 0);
    check_eq("fz_idx", idx, 1);
    en = 1'b1;
    step(2);
    check_eq("fz_hold", idx, 1);
    step(1);
    check_eq("fz_step", idx, 2);

    // Only the current position unmasked: idx holds, no wrap.
    skip_mask = 8'hFB;
    step(4);
    check_eq("solo_idx", idx, 2);
    check_eq("solo_wrap", wrap, 0);
    check_eq("solo_valid", idx_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
